div2_sequencer: RTL and testbench



---
 rtl/div2_sequencer.sv | 153 +++++++++++++++
 tb/tb_div2_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div2_sequencer.sv
// Bit-serial restoring divider sequencer: reads a 16-bit dividend and an 8-bit divisor from
// data memory and writes floor((dividend<<8)/divisor) back as three bytes. Define DIV2_ROUND_EN for half-LSB rounding.
module div2_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 2,
  parameter int RES_ADDR = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

`ifdef DIV2_ROUND_EN
  localparam int QW = 25;
`else
  localparam int QW = 24;
`endif

  typedef enum logic [3:0] {
    IDLE, RD_HI, RD_LO, RD_DIV, DIV, WR_HI, WR_MID, WR_LO, DONE
  } state_t;

  state_t        state;
  logic          start_q;
  logic [15:0]   dividend;
  logic [7:0]    divisor;
  logic [23:0]   num;
  logic [7:0]    rem;
  logic [QW-2:0] quot;
  logic [4:0]    count;
  logic [23:0]   res;

  logic          launch;
  logic [8:0]    r_shift;
  logic [8:0]    diff;
  logic          ge;
  logic [7:0]    rem_next;
  logic [QW-1:0] q_next;
  logic [23:0]   res_next;

  assign launch = Start & ~start_q;

  // NOTE: every variable is assigned unconditionally here, so no latch can be inferred.
  always_comb begin
    r_shift  = {rem, num[23]};
    diff     = r_shift - {1'b0, divisor};
    // r_shift < 2*divisor, so a set diff[8] can only mean a borrow.
    ge       = ~diff[8];
    rem_next = ge ? diff[7:0] : r_shift[7:0];
    q_next   = {quot, ge};
`ifdef DIV2_ROUND_EN
    res_next = q_next[QW-1:1] + {23'd0, q_next[0]};
`else
    res_next = q_next;
`endif
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      Ack         <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      dividend    <= '0;
      divisor     <= '0;
      num         <= '0;
      rem         <= '0;
      quot        <= '0;
      count       <= '0;
      res         <= '0;
    end else begin
      start_q <= Start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state    <= RD_HI;
            Ack      <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= ADDR_W'(OPA_ADDR);
          end
        end
        RD_HI: begin
          dividend[15:8] <= mem_rd_data;
          mem_addr       <= ADDR_W'(OPA_ADDR + 1);
          state          <= RD_LO;
        end
        RD_LO: begin
          dividend[7:0] <= mem_rd_data;
          mem_addr      <= ADDR_W'(OPB_ADDR);
          state         <= RD_DIV;
        end
        RD_DIV: begin
          divisor <= mem_rd_data;
          if (mem_rd_data == 8'd0) begin
            res         <= 24'hFFFFFF;
            mem_wr_en   <= 1'b1;
            mem_addr    <= ADDR_W'(RES_ADDR);
            mem_wr_data <= 8'hFF;
            state       <= WR_HI;
          end else begin
            num   <= {dividend, 8'h00};
            rem   <= '0;
            quot  <= '0;
            count <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          num   <= {num[22:0], 1'b0};
          rem   <= rem_next;
          quot  <= q_next[QW-2:0];
          count <= count + 5'd1;
          if (count == 5'(QW - 1)) begin
            res         <= res_next;
            mem_wr_en   <= 1'b1;
            mem_addr    <= ADDR_W'(RES_ADDR);
            mem_wr_data <= res_next[23:16];
            state       <= WR_HI;
          end
        end
        WR_HI: begin
          mem_addr    <= ADDR_W'(RES_ADDR + 1);
          mem_wr_data <= res[15:8];
          state       <= WR_MID;
        end
        WR_MID: begin
          mem_addr    <= ADDR_W'(RES_ADDR + 2);
          mem_wr_data <= res[7:0];
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
          Ack       <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div2_sequencer.sv
// Self-checking bench for div2_sequencer: a run-level timeline model checks busy/Ack/mem_wr_en every
// cycle, and directed runs check the written quotient, the write count and the launch-to-Ack latency.
module tb_div2_sequencer;

`ifdef DIV2_ROUND_EN
  localparam int ITERS = 25;
  localparam logic [23:0] Q_2_3 = 24'h0000AB;
`else
  localparam int ITERS = 24;
  localparam logic [23:0] Q_2_3 = 24'h0000AA;
`endif
  localparam int LAT_NZ = ITERS + 7;
  localparam int LAT_Z  = 7;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  int         wr_count;

  int n_cmp;
  int n_bad;

  div2_sequencer #(.ADDR_W(8), .OPA_ADDR(0), .OPB_ADDR(2), .RES_ADDR(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rd_data = mem[mem_addr];

  // Single writer for the memory: bench preload port plus the DUT write port.
  always @(posedge Clk) begin
    if (host_we) mem[host_addr] <= host_data;
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_q(input logic [15:0] a, input logic [7:0] b);
    int unsigned t;
    if (b == 8'd0) return 24'hFFFFFF;
`ifdef DIV2_ROUND_EN
    t = ({16'd0, a} << 9) / {24'd0, b};
    return 24'((t >> 1) + (t & 1));
`else
    t = ({16'd0, a} << 8) / {24'd0, b};
    return 24'(t);
`endif
  endfunction

  // Run-level model: a run lasts a fixed number of edges set by the divisor seen at launch.
  bit m_valid, m_running, m_ack, m_sq;
  int m_k, m_len;

  always @(posedge Clk) begin
    if (Reset) begin
      m_valid   = 1'b1;
      m_running = 1'b0;
      m_ack     = 1'b0;
      m_sq      = 1'b0;
    end else begin
      if (m_running) begin
        m_k++;
        if (m_k == m_len) begin
          m_running = 1'b0;
          m_ack     = 1'b1;
        end
      end else if (Start && !m_sq) begin
        m_running = 1'b1;
        m_k       = 1;
        m_ack     = 1'b0;
        m_len     = (mem[2] == 8'd0) ? LAT_Z : LAT_NZ;
      end
      m_sq = Start;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_running));
      check("ack", 32'(Ack), 32'(m_ack));
      check("wr_en", 32'(mem_wr_en), 32'(m_running && (m_k >= m_len - 3)));
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    @(posedge Clk); #2;
    host_we   = 1'b0;
  endtask

  task automatic load(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv);
    host_write(8'd0, hi);
    host_write(8'd1, lo);
    host_write(8'd2, dv);
    for (int i = 4; i < 7; i++) host_write(8'(i), 8'h5A);
  endtask

  // Counts edges from the launch edge (edge 1) until Ack is seen; optionally disturbs mid-run.
  task automatic wait_ack(input int exp_lat, input string tag, input bit disturb);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge Clk); #1;
      cnt++;
      Start   = 1'b0;
      host_we = 1'b0;
      if (disturb && cnt == 5) begin
        Start     = 1'b1;
        host_we   = 1'b1;
        host_addr = 8'd2;
        host_data = 8'd0;
      end
      if (Ack === 1'b1) got = 1'b1;
    end
    check({tag, " latency"}, got ? 32'(cnt) : 32'd0, 32'(exp_lat));
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                              input logic [23:0] exp_lit, input int w0);
    check({tag, " model"}, 32'(model_q(a, b)), 32'(exp_lit));
    check({tag, " result"}, 32'({mem[4], mem[5], mem[6]}), 32'(model_q(a, b)));
    check({tag, " writes"}, 32'(wr_count - w0), 32'd3);
  endtask

  task automatic run(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] dv,
                     input logic [23:0] exp_lit, input int exp_lat, input string tag,
                     input bit disturb);
    int w0;
    load(hi, lo, dv);
    w0    = wr_count;
    Start = 1'b1;
    wait_ack(exp_lat, tag, disturb);
    check_result(tag, {hi, lo}, dv, exp_lit, w0);
  endtask

  initial begin
    int w0;
    n_cmp    = 0;
    n_bad    = 0;
    wr_count = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    host_we  = 1'b0;
    host_addr = '0;
    host_data = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset Ack", 32'(Ack), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_en", 32'(mem_wr_en), 32'd0);
    check("reset addr", 32'(mem_addr), 32'd0);
    check("reset wr_data", 32'(mem_wr_data), 32'd0);
    #1;

    // Start held high through reset launches once on the first post-reset edge: 2/3.
    Start = 1'b1;
    load(8'h00, 8'h02, 8'd3);
    w0    = wr_count;
    Reset = 1'b0;
    wait_ack(LAT_NZ, "2/3 start-in-reset", 1'b0);
    check_result("2/3 start-in-reset", 16'd2, 8'd3, Q_2_3, w0);

    // Each following run launches from DONE, so Ack must drop after the launch edge.
    run(8'h32, 8'h00, 8'd25,  24'h020000, LAT_NZ, "12800/25", 1'b0);
    run(8'h00, 8'h03, 8'd255, 24'h000003, LAT_NZ, "3/255", 1'b0);
    run(8'hFF, 8'hFF, 8'd1,   24'hFFFF00, LAT_NZ, "65535/1", 1'b0);
    run(8'h12, 8'h34, 8'd0,   24'hFFFFFF, LAT_Z,  "x/0", 1'b0);
    // Extra Start pulse while busy and a divisor overwrite after it was sampled.
    run(8'h32, 8'h00, 8'd25,  24'h020000, LAT_NZ, "12800/25 disturbed", 1'b1);

    // Reset during DIV iteration 10 (count==10 after edge 14 counting launch as edge 1).
    load(8'h32, 8'h00, 8'd25);
    w0    = wr_count;
    Start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midrun busy", 32'(busy), 32'd0);
    check("midrun Ack", 32'(Ack), 32'd0);
    check("midrun wr_en", 32'(mem_wr_en), 32'd0);
    #1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check("midrun writes", 32'(wr_count - w0), 32'd0);
    check("midrun untouched", 32'({mem[4], mem[5], mem[6]}), 32'h5A5A5A);

    run(8'h32, 8'h00, 8'd25, 24'h020000, LAT_NZ, "12800/25 after reset", 1'b0);

    repeat (3) @(posedge Clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
